// File: rtl/int_ctrl.sv
// int_ctrl: receiving end of the CPU interrupt path.
// Raw request lines are sampled and edge-detected. Each rising edge sets a
// latched pending bit. Masked pending bits are arbitrated by fixed priority,
// where the lowest index wins. The winner is presented to the CPU as a
// registered INT plus int_vec, and the ack / eret handshake is tracked.
// Edges that land on an already-pending bit are counted in a saturating
// lost_cnt.
//
// Optional feature, macro INT_SYNC_EN:
//   defined   - each INT_src bit passes through a two-flop synchronizer before
//               the edge-history flop. Edge-to-pending latency is 3 edges.
//   undefined - INT_src is sampled by a single flop. Use this only for
//               sources that are already synchronous to clk. Latency is
//               2 edges.
module int_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] INT_src,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic               int_en,
    input  logic               int_ack,
    input  logic               eret,
    output logic               INT,
    output logic [VEC_W-1:0]   int_vec,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [7:0]         lost_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state;

    // Sampled level s of each request line, and its one-cycle history.
    logic [NUM_SRC-1:0] lvl_p1;
    logic [NUM_SRC-1:0] hist_p2;

    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] req_mask;
    logic [NUM_SRC-1:0] pending_nxt;
    logic               lost_any;

    // Lowest set index of a request vector, which gives fixed priority.
    function automatic logic [VEC_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] bits);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = VEC_W'(i);
            end
        end
        return idx;
    endfunction

    // Saturating 8-bit increment for the lost-event counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

`ifdef INT_SYNC_EN
    logic [NUM_SRC-1:0] sync_p0;

    // Two-flop synchronizer for request lines from a foreign clock domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            lvl_p1  <= '0;
        end else begin
            sync_p0 <= INT_src;
            lvl_p1  <= sync_p0;
        end
    end
`else
    // Single sampling flop for request lines already synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lvl_p1 <= '0;
        end else begin
            lvl_p1 <= INT_src;
        end
    end
`endif

    // Edge history. It resets to 0, so a line held high through reset
    // produces exactly one edge after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_p2 <= '0;
        end else begin
            hist_p2 <= lvl_p1;
        end
    end

    // Rising-edge detection and the acknowledge clear of the serviced bit.
    always_comb begin
        edge_det = lvl_p1 & ~hist_p2;
        req_mask = pending & int_mask;
        clr_mask = '0;
        if (state == REQ && int_ack) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (int_vec == VEC_W'(i)) begin
                    clr_mask[i] = 1'b1;
                end
            end
        end
        // A new edge wins over a same-cycle clear. It is not a lost event
        // because the bit it lands on is being consumed.
        pending_nxt = (pending & ~clr_mask) | edge_det;
        lost_any    = |(edge_det & pending & ~clr_mask);
    end

    // Pending latch and saturating lost-event counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= '0;
            lost_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            if (lost_any) begin
                lost_cnt <= sat_inc(lost_cnt);
            end
        end
    end

    // Handshake FSM. INT, int_vec and in_service are all registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            INT        <= 1'b0;
            int_vec    <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_en && (req_mask != '0)) begin
                        int_vec <= lowest_idx(req_mask);
                        INT     <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // The presented vector is frozen. Mask and enable
                    // changes here do not withdraw the request.
                    if (int_ack) begin
                        INT        <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    INT        <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl. Directed vectors with hand-computed expectations.
// Vectors expected on each INT presentation are queued by the stimulus and
// popped by a separate monitor on every rising edge of INT.
module tb_int_ctrl;

`ifdef INT_SYNC_EN
    localparam int PEND_LAT = 3;
`else
    localparam int PEND_LAT = 2;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] INT_src;
    logic [7:0] int_mask;
    logic       int_en;
    logic       int_ack;
    logic       eret;
    logic       INT;
    logic [2:0] int_vec;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;
    int exp_vec[$];
    logic int_prev = 1'b0;

    int_ctrl #(.NUM_SRC(8), .VEC_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .INT_src    (INT_src),
        .int_mask   (int_mask),
        .int_en     (int_en),
        .int_ack    (int_ack),
        .eret       (eret),
        .INT        (INT),
        .int_vec    (int_vec),
        .in_service (in_service),
        .pending    (pending),
        .lost_cnt   (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One-cycle pulse on the given lines. It returns once the resulting
    // pending bits are visible.
    task automatic pulse(input logic [7:0] v);
        INT_src = v;
        tick(1);
        INT_src = 8'h00;
        tick(PEND_LAT - 1);
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
    endtask

    // Monitor: every rising edge of INT consumes one expected vector.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (INT && !int_prev) begin
                checks++;
                if (exp_vec.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_int: got vec %0d want no INT", int_vec);
                end else begin
                    int e;
                    e = exp_vec.pop_front();
                    if (int_vec !== 3'(e)) begin
                        errors++;
                        $display("FAIL int_vec: got %0d want %0d", int_vec, e);
                    end
                end
            end
            int_prev = INT;
        end
    end

    initial begin
        rst = 1'b0; INT_src = 8'hFF; int_mask = 8'h00; int_en = 1'b0;
        int_ack = 1'b0; eret = 1'b0;

        // Reset held for two cycles with all request lines high.
        tick(2);
        chk("rst_INT", 32'(INT), 0);
        chk("rst_vec", 32'(int_vec), 0);
        chk("rst_insvc", 32'(in_service), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_lost", 32'(lost_cnt), 0);
        rst = 1'b1;
        tick(PEND_LAT - 1);
        chk("rel_pending_early", 32'(pending), 0);
        tick(1);
        chk("rel_pending_ff", 32'(pending), 32'hFF);
        chk("rel_no_int", 32'(INT), 0);

        // Clear everything with a second reset, lines low.
        INT_src = 8'h00; rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("rst2_pending", 32'(pending), 0);
        tick(2);

        // Single request on source 5.
        int_mask = 8'hFF; int_en = 1'b1;
        exp_vec.push_back(5);
        pulse(8'h20);
        chk("s5_pending", 32'(pending), 32'h20);
        chk("s5_int_early", 32'(INT), 0);
        tick(1);
        chk("s5_int", 32'(INT), 1);
        chk("s5_vec", 32'(int_vec), 5);
        tick(2);
        chk("s5_int_held", 32'(INT), 1);
        do_ack();
        chk("s5_ack_int", 32'(INT), 0);
        chk("s5_ack_insvc", 32'(in_service), 1);
        chk("s5_ack_pending", 32'(pending), 0);
        do_eret();
        chk("s5_eret_insvc", 32'(in_service), 0);
        chk("s5_vec_hold", 32'(int_vec), 5);
        tick(2);
        chk("s5_idle_int", 32'(INT), 0);

        // Priority: sources 6 and 2 together, 2 first.
        exp_vec.push_back(2);
        exp_vec.push_back(6);
        pulse(8'h44);
        chk("pri_pending", 32'(pending), 32'h44);
        tick(1);
        chk("pri_vec2", 32'(int_vec), 2);
        do_ack();
        chk("pri_pending6", 32'(pending), 32'h40);
        chk("pri_insvc", 32'(in_service), 1);
        do_eret();
        chk("pri_eret_int", 32'(INT), 0);
        tick(1);
        chk("pri_int6", 32'(INT), 1);
        chk("pri_vec6", 32'(int_vec), 6);
        do_ack();
        do_eret();
        chk("pri_pending_done", 32'(pending), 0);

        // Masking, then unmask raises INT one cycle later.
        int_mask = 8'h00;
        pulse(8'h02);
        chk("mask_pending", 32'(pending), 32'h02);
        tick(3);
        chk("mask_no_int", 32'(INT), 0);
        exp_vec.push_back(1);
        int_mask = 8'h02;
        tick(1);
        chk("unmask_int", 32'(INT), 1);
        chk("unmask_vec", 32'(int_vec), 1);
        do_ack();
        do_eret();

        // Same sequence with int_en low: no INT, and ack in IDLE is ignored.
        int_en = 1'b0; int_mask = 8'h00;
        pulse(8'h02);
        int_mask = 8'h02;
        tick(3);
        chk("en0_no_int", 32'(INT), 0);
        do_ack();
        chk("ack_idle_pending", 32'(pending), 32'h02);
        chk("ack_idle_insvc", 32'(in_service), 0);

        // Three edges on masked source 3, so two are lost.
        pulse(8'h08);
        pulse(8'h08);
        pulse(8'h08);
        chk("lost_two", 32'(lost_cnt), 2);
        chk("lost_pending", 32'(pending), 32'h0A);

        // Edge on source 3 coincident with its acknowledge.
        int_en = 1'b1; int_mask = 8'h08;
        exp_vec.push_back(3);
        tick(1);
        chk("col_int", 32'(INT), 1);
        INT_src = 8'h08;
        tick(1);
        INT_src = 8'h00;
        tick(PEND_LAT - 2);
        do_ack();
        chk("col_pending", 32'(pending), 32'h0A);
        chk("col_lost", 32'(lost_cnt), 2);
        chk("col_insvc", 32'(in_service), 1);
        exp_vec.push_back(3);
        do_eret();
        tick(1);
        chk("col_reint", 32'(INT), 1);
        do_ack();
        do_eret();
        chk("col_pending_done", 32'(pending), 32'h02);

        // Saturation of lost_cnt on masked pending source 1.
        int_en = 1'b0;
        for (int i = 0; i < 252; i++) pulse(8'h02);
        chk("lost_254", 32'(lost_cnt), 254);
        for (int i = 0; i < 48; i++) pulse(8'h02);
        chk("lost_sat", 32'(lost_cnt), 255);

        // Reset in the middle of a handshake.
        int_en = 1'b1; int_mask = 8'hFF;
        exp_vec.push_back(1);
        tick(1);
        chk("mid_int", 32'(INT), 1);
        do_ack();
        pulse(8'h10);
        chk("mid_insvc", 32'(in_service), 1);
        chk("mid_pending", 32'(pending), 32'h10);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("mid_rst_insvc", 32'(in_service), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_lost", 32'(lost_cnt), 0);
        chk("mid_rst_int", 32'(INT), 0);
        chk("mid_rst_vec", 32'(int_vec), 0);
        do_eret();
        chk("mid_eret_insvc", 32'(in_service), 0);
        tick(3);
        chk("mid_eret_int", 32'(INT), 0);

        chk("queue_empty", 32'(exp_vec.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
